pc_ctrl: RTL and testbench
==========================

Name: pc_ctrl

Overview:
Next-PC sequencer for the 8-stage pipeline. It sits in front of PCreg and drives its npc_in and halt inputs.
- Picks the next fetch address from sequential, jump, branch, jr, eret and exception sources by fixed priority.
- Holds a redirect that arrives during a stall until the stall clears.
- Issues a multi-cycle wrong-path flush after each applied redirect, and latches halt permanently.

Parameters:
RESET_PC, 32'h00400000, value driven on npc_out while in reset
EXC_VECTOR, 32'h00400004, exception entry address
FLUSH_CYCLES, 3, cycles flush stays high after a redirect is applied (1..15)
CNT_W, 16, width of the saturating redirect counter

Ports:
pc_clk  in  1  rising-edge clock (same clock as PCreg)
reset  in  1  synchronous, active-low reset
pc  in  32  current PC from PCreg
npc  in  32  pc+4 from PCreg
jpc_head  in  4  pc[31:28] from PCreg
stall  in  1  hazard-unit stall; hold the PC this cycle
jump_req  in  1  j/jal decoded
j_index  in  26  jump instr_index
br_req  in  1  branch resolved taken
br_target  in  32  branch target
jr_req  in  1  jr/jalr
jr_target  in  32  register target
eret_req  in  1  eret
epc  in  32  return address
exc_req  in  1  exception raised
halt_req  in  1  halt instruction reached commit
npc_out  out  32  to PCreg npc_in
pc_halt  out  1  to PCreg halt
flush  out  1  kill wrong-path stages
busy_flush  out  1  state==FLUSH
redirect_cnt  out  CNT_W  applied-redirect count, saturating

Behaviour:
- Reset is sampled only at the pc_clk rising edge while reset==0. After reset:
  - state=RUN, pend_v=0, pend_tgt=0, flush_cnt=0, redirect_cnt=0, halted=0.
  - While reset==0, npc_out=RESET_PC, pc_halt=0 and flush=0 (combinational override).
- Redirect request priority, highest first: exc (EXC_VECTOR) > eret (epc) > jr (jr_target) > br (br_target) > jump.
  - Jump target = {jpc_head, j_index, 2'b00}.
  - The winner is the current request req_v/req_tgt.
- FSM states: RUN, FLUSH, HALT.
- RUN:
  - If stall=1:
    - npc_out=pc.
    - If req_v and !pend_v, capture req_tgt into pend_tgt and set pend_v=1.
    - If pend_v and exc_req, overwrite pend_tgt with EXC_VECTOR (exception always wins).
  - If stall=0 with pend_v: npc_out=pend_tgt, clear pend_v, flush=1, flush_cnt=FLUSH_CYCLES-1, go to FLUSH if FLUSH_CYCLES>1.
  - Else if stall=0 with req_v: npc_out=req_tgt, with the same flush/FLUSH entry as above.
  - Else npc_out=npc.
  - Every applied redirect increments redirect_cnt, saturating at all-ones.
- FLUSH:
  - flush=1 every cycle; flush_cnt decrements; go to RUN when it reaches 0.
  - Only exc_req is honoured: it applies EXC_VECTOR at once (when stall=0) and reloads flush_cnt. All other requests are ignored.
  - npc_out=pc if stall=1, else npc.
- HALT:
  - Enter from any state on halt_req=1, unless exc_req is also 1: exception wins and halt is dropped.
  - pc_halt=1 from the entry cycle onward; npc_out=pc; flush=0.
  - pend_v is cleared and all requests are ignored. Only reset exits.
- Simultaneous stall + exc with pend_v=0: exception is latched and applied on the first cycle with stall=0.
- Output latency: npc_out, pc_halt and flush are combinational from state and inputs. PCreg registers npc_out, so the redirect target appears on pc one cycle after it is applied.
- Reset asserted mid-FLUSH or in HALT: the next state is RUN, and pending work and counters are discarded.

Optional Feature:
- PCCTRL_MISALIGN_EN defined:
  - Any redirect target with tgt[1:0]!=0 is replaced by EXC_VECTOR.
  - Adds a 1-bit output misalign_err that pulses for one cycle when the bad redirect is applied.
- Not defined: targets pass through unchanged and the misalign_err port is absent.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> npc_out=32'h00400000, pc_halt=0, flush=0, redirect_cnt=0.
- Branch: pc=0x00400010, br_req=1, br_target=0x00400100 -> npc_out=0x00400100 that cycle; flush high for 3 cycles; redirect_cnt=1.
- Stalled redirect: stall=1 with jump_req=1, j_index=26'h0100040, jpc_head=0 for 2 cycles -> npc_out=pc both cycles; stall drops -> npc_out=0x00400100 (single apply, redirect_cnt +1).
- Priority: exc_req, jr_req and br_req in the same cycle -> npc_out=0x00400004. Later, br_req during FLUSH -> ignored, npc_out=npc.
- Halt: halt_req=1 for 1 cycle -> pc_halt stays 1 and npc_out=pc for 10 cycles despite br_req; reset=0 -> RUN, npc_out=0x00400000.
- PCCTRL_MISALIGN_EN: jr_target=0x00400102 -> npc_out=0x00400004, misalign_err pulses 1 cycle.

Source files
------------

// File: rtl/pc_ctrl.sv
// Next-PC sequencer: prioritised redirects, stall-held pending redirect, wrong-path flush, sticky halt.
// Optional build macro PCCTRL_MISALIGN_EN: misaligned redirect targets become EXC_VECTOR, flagged on misalign_err.
//
//   state    | meaning
//   ST_RUN   | normal sequencing; redirects applied or held while stalled
//   ST_FLUSH | wrong-path flush in progress; only exceptions are honoured
//   ST_HALT  | PC frozen until reset
module pc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h00400000,
    parameter logic [31:0] EXC_VECTOR   = 32'h00400004,
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              pc_clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic [31:0]       npc,
    input  logic [3:0]        jpc_head,
    input  logic              stall,
    input  logic              jump_req,
    input  logic [25:0]       j_index,
    input  logic              br_req,
    input  logic [31:0]       br_target,
    input  logic              jr_req,
    input  logic [31:0]       jr_target,
    input  logic              eret_req,
    input  logic [31:0]       epc,
    input  logic              exc_req,
    input  logic              halt_req,
    output logic [31:0]       npc_out,
    output logic              pc_halt,
    output logic              flush,
    output logic              busy_flush,
    output logic [CNT_W-1:0]  redirect_cnt
`ifdef PCCTRL_MISALIGN_EN
    ,
    output logic              misalign_err
`endif
);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t             state_q, state_d;
    logic               pend_v_q, pend_v_d;
    logic [31:0]        pend_tgt_q, pend_tgt_d;
    logic               pend_bad_q, pend_bad_d;
    logic [3:0]         flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   redirect_cnt_q;

    logic               req_v;
    logic [31:0]        req_raw;
    logic [31:0]        req_tgt;
    logic               req_bad;
    logic               halt_take;
    logic               apply;
    logic               apply_bad;
    logic [31:0]        npc_c;
    logic               flush_c;
    logic               halt_c;

    always_comb begin
        req_v   = 1'b1;
        req_raw = '0;
        if (exc_req)       req_raw = EXC_VECTOR;
        else if (eret_req) req_raw = epc;
        else if (jr_req)   req_raw = jr_target;
        else if (br_req)   req_raw = br_target;
        else if (jump_req) req_raw = {jpc_head, j_index, 2'b00};
        else               req_v   = 1'b0;
    end

`ifdef PCCTRL_MISALIGN_EN
    assign req_bad = req_v && (req_raw[1:0] != 2'b00);
    assign req_tgt = req_bad ? EXC_VECTOR : req_raw;
`else
    assign req_bad = 1'b0;
    assign req_tgt = req_raw;
`endif

    // An exception in the same cycle as halt_req takes precedence and the halt is dropped.
    assign halt_take = halt_req && !exc_req;

    always_comb begin
        state_d     = state_q;
        pend_v_d    = pend_v_q;
        pend_tgt_d  = pend_tgt_q;
        pend_bad_d  = pend_bad_q;
        flush_cnt_d = flush_cnt_q;
        npc_c       = npc;
        flush_c     = 1'b0;
        halt_c      = 1'b0;
        apply       = 1'b0;
        apply_bad   = 1'b0;

        if (state_q == ST_HALT || halt_take) begin
            halt_c      = 1'b1;
            npc_c       = pc;
            pend_v_d    = 1'b0;
            flush_cnt_d = '0;
            state_d     = ST_HALT;
        end else if (state_q == ST_FLUSH) begin
            flush_c = 1'b1;
            npc_c   = stall ? pc : npc;
            if (exc_req && !stall) begin
                npc_c = EXC_VECTOR;
                apply = 1'b1;
            end else begin
                flush_cnt_d = flush_cnt_q - 4'd1;
                if (flush_cnt_q <= 4'd1) state_d = ST_RUN;
            end
        end else if (stall) begin
            npc_c = pc;
            if (req_v && !pend_v_q) begin
                pend_v_d   = 1'b1;
                pend_tgt_d = req_tgt;
                pend_bad_d = req_bad;
            end
            if (pend_v_q && exc_req) begin
                pend_tgt_d = EXC_VECTOR;
                pend_bad_d = 1'b0;
            end
        end else if (pend_v_q) begin
            npc_c     = pend_tgt_q;
            pend_v_d  = 1'b0;
            apply     = 1'b1;
            apply_bad = pend_bad_q;
        end else if (req_v) begin
            npc_c     = req_tgt;
            apply     = 1'b1;
            apply_bad = req_bad;
        end

        if (apply) begin
            flush_c     = 1'b1;
            flush_cnt_d = FLUSH_RELOAD;
            state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end
    end

    always_ff @(posedge pc_clk) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            pend_v_q       <= 1'b0;
            pend_tgt_q     <= '0;
            pend_bad_q     <= 1'b0;
            flush_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_v_q    <= pend_v_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_bad_q  <= pend_bad_d;
            flush_cnt_q <= flush_cnt_d;
            if (apply && (redirect_cnt_q != '1))
                redirect_cnt_q <= redirect_cnt_q + 1'b1;
        end
    end

    assign npc_out      = reset ? npc_c : RESET_PC;
    assign pc_halt      = reset && halt_c;
    assign flush        = reset && flush_c;
    assign busy_flush   = (state_q == ST_FLUSH);
    assign redirect_cnt = redirect_cnt_q;

`ifdef PCCTRL_MISALIGN_EN
    assign misalign_err = reset && apply && apply_bad;
`else
    logic unused_bad;
    assign unused_bad = apply_bad;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed plan steps followed by random traffic,
// compared every cycle against a queue/counter model of the sequencing rules.
module tb_pc_ctrl;
    localparam logic [31:0] RST_PC = 32'h00400000;
    localparam logic [31:0] EXC    = 32'h00400004;
    localparam int          F      = 3;
    localparam int          CMAX   = 65535;

    logic        pc_clk = 1'b0;
    logic        reset  = 1'b0;
    logic [31:0] pc = '0, npc = 32'd4;
    logic [3:0]  jpc_head = '0;
    logic        stall = 0, jump_req = 0, br_req = 0, jr_req = 0, eret_req = 0, exc_req = 0, halt_req = 0;
    logic [25:0] j_index = '0;
    logic [31:0] br_target = '0, jr_target = '0, epc = '0;
    logic [31:0] npc_out;
    logic        pc_halt, flush, busy_flush;
    logic [15:0] redirect_cnt;
`ifdef PCCTRL_MISALIGN_EN
    logic        misalign_err;
`endif

    pc_ctrl dut (
        .pc_clk(pc_clk), .reset(reset), .pc(pc), .npc(npc), .jpc_head(jpc_head),
        .stall(stall), .jump_req(jump_req), .j_index(j_index), .br_req(br_req),
        .br_target(br_target), .jr_req(jr_req), .jr_target(jr_target),
        .eret_req(eret_req), .epc(epc), .exc_req(exc_req), .halt_req(halt_req),
        .npc_out(npc_out), .pc_halt(pc_halt), .flush(flush), .busy_flush(busy_flush),
        .redirect_cnt(redirect_cnt)
`ifdef PCCTRL_MISALIGN_EN
        , .misalign_err(misalign_err)
`endif
    );

    always #5 pc_clk = ~pc_clk;

    int total = 0;
    int bad   = 0;

    // model: halted flag, remaining flush cycles, at most one pending redirect
    bit          m_halted = 0;
    int          m_fl     = 0;
    logic [31:0] m_pend[$];
    bit          m_pbad[$];
    int          m_cnt    = 0;

    logic [31:0] o_npc;
    logic        o_flush, o_halt, o_err;
    int          o_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h, wanted %h", tag, obs, exp);
        end
    endtask

    task automatic pick(output bit v, output logic [31:0] t, output bit b);
        v = 1; b = 0;
        if (exc_req)       t = EXC;
        else if (eret_req) t = epc;
        else if (jr_req)   t = jr_target;
        else if (br_req)   t = br_target;
        else if (jump_req) t = {jpc_head, j_index, 2'b00};
        else begin v = 0; t = '0; end
`ifdef PCCTRL_MISALIGN_EN
        if (v && t[1:0] != 2'b00) begin t = EXC; b = 1; end
`endif
    endtask

    // evaluate one cycle mid-period, compare, update model, then advance past the edge
    task automatic cycle(input string tag);
        bit v, b, app;
        logic [31:0] t, e_npc;
        bit e_flush, e_halt, e_err;
        #3;
        o_npc = npc_out; o_flush = flush; o_halt = pc_halt; o_cnt = int'(redirect_cnt);
`ifdef PCCTRL_MISALIGN_EN
        o_err = misalign_err;
`else
        o_err = 1'b0;
`endif
        check({tag, "_busy"}, 32'(busy_flush), 32'(m_fl > 0));
        check({tag, "_cnt"}, 32'(redirect_cnt), 32'(m_cnt));
        app = 0; e_flush = 0; e_halt = 0; e_err = 0; e_npc = npc;
        pick(v, t, b);
        if (!reset) begin
            e_npc = RST_PC;
            m_halted = 0; m_fl = 0; m_cnt = 0;
            m_pend.delete(); m_pbad.delete();
        end else if (m_halted || (halt_req && !exc_req)) begin
            e_halt = 1; e_npc = pc;
            m_halted = 1; m_fl = 0;
            m_pend.delete(); m_pbad.delete();
        end else if (m_fl > 0) begin
            e_flush = 1;
            e_npc = stall ? pc : npc;
            if (exc_req && !stall) begin e_npc = EXC; app = 1; end
            else m_fl--;
        end else if (stall) begin
            e_npc = pc;
            if (m_pend.size() == 0 && v) begin m_pend.push_back(t); m_pbad.push_back(b); end
            else if (m_pend.size() > 0 && exc_req) begin m_pend[0] = EXC; m_pbad[0] = 0; end
        end else if (m_pend.size() > 0) begin
            e_npc = m_pend.pop_front(); e_err = m_pbad.pop_front(); app = 1;
        end else if (v) begin
            e_npc = t; e_err = b; app = 1;
        end
        if (app) begin
            e_flush = 1;
            m_fl = F - 1;
            if (m_cnt < CMAX) m_cnt++;
        end
        check({tag, "_npc"}, o_npc, e_npc);
        check({tag, "_flush"}, 32'(o_flush), 32'(e_flush));
        check({tag, "_halt"}, 32'(o_halt), 32'(e_halt));
`ifdef PCCTRL_MISALIGN_EN
        check({tag, "_merr"}, 32'(o_err), 32'(e_err));
`endif
        @(posedge pc_clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; jump_req = 0; br_req = 0; jr_req = 0; eret_req = 0; exc_req = 0; halt_req = 0;
    endtask

    task automatic set_pc(input logic [31:0] p);
        pc = p; npc = p + 32'd4;
    endtask

    initial begin
        @(posedge pc_clk);
        #1;
        idle();
        set_pc(32'h00400000);

        reset = 0;
        cycle("rst0");
        check("rst_npc", o_npc, RST_PC);
        cycle("rst1");
        check("rst_npc2", o_npc, RST_PC);
        check("rst_flush", 32'(o_flush), 32'd0);
        check("rst_halt", 32'(o_halt), 32'd0);
        reset = 1;
        cycle("run0");
        check("rst_cnt", 32'(o_cnt), 32'd0);

        set_pc(32'h00400010); br_req = 1; br_target = 32'h00400100;
        cycle("br");
        check("br_npc", o_npc, 32'h00400100);
        check("br_fl0", 32'(o_flush), 32'd1);
        br_req = 0; set_pc(32'h00400100);
        cycle("br_f1");
        check("br_fl1", 32'(o_flush), 32'd1);
        cycle("br_f2");
        check("br_fl2", 32'(o_flush), 32'd1);
        cycle("br_end");
        check("br_fl3", 32'(o_flush), 32'd0);
        check("br_cnt", 32'(o_cnt), 32'd1);

        set_pc(32'h00400104); stall = 1; jump_req = 1; j_index = 26'h0100040; jpc_head = 4'h0;
        cycle("st0");
        check("st0_npc", o_npc, 32'h00400104);
        cycle("st1");
        check("st1_npc", o_npc, 32'h00400104);
        stall = 0;
        cycle("st_go");
        check("st_go_npc", o_npc, 32'h00400100);
        jump_req = 0; set_pc(32'h00400100);
        cycle("st_f1");
        cycle("st_f2");
        cycle("st_end");
        check("st_cnt", 32'(o_cnt), 32'd2);

        exc_req = 1; jr_req = 1; jr_target = 32'h00401000; br_req = 1; br_target = 32'h00402000;
        cycle("prio");
        check("prio_npc", o_npc, EXC);
        idle(); set_pc(32'h00400004); br_req = 1;
        cycle("fl_ign");
        check("fl_ign_npc", o_npc, 32'h00400008);
        br_req = 0;
        cycle("fl_a");
        cycle("fl_b");

        set_pc(32'h00400200); halt_req = 1;
        cycle("halt_in");
        halt_req = 0; br_req = 1; br_target = 32'h00400300;
        for (int i = 0; i < 10; i++) begin
            cycle("halted");
            check("halt_hold", 32'(o_halt), 32'd1);
            check("halt_npc", o_npc, 32'h00400200);
        end
        br_req = 0; reset = 0;
        cycle("halt_rst");
        check("halt_rst_npc", o_npc, RST_PC);
        check("halt_rst_h", 32'(o_halt), 32'd0);
        reset = 1;
        cycle("post_halt");

`ifdef PCCTRL_MISALIGN_EN
        jr_req = 1; jr_target = 32'h00400102;
        cycle("mis");
        check("mis_npc", o_npc, EXC);
        check("mis_err", 32'(o_err), 32'd1);
        jr_req = 0;
        cycle("mis_after");
        check("mis_err_off", 32'(o_err), 32'd0);
        cycle("mis_f2");
`endif

        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) != 0);
            stall    = ($urandom_range(0, 2) == 0);
            exc_req  = ($urandom_range(0, 15) == 0);
            eret_req = ($urandom_range(0, 9) == 0);
            jr_req   = ($urandom_range(0, 9) == 0);
            br_req   = ($urandom_range(0, 7) == 0);
            jump_req = ($urandom_range(0, 7) == 0);
            halt_req = ($urandom_range(0, 399) == 0);
            set_pc($urandom & 32'hFFFF_FFFC);
            jpc_head  = 4'($urandom);
            j_index   = 26'($urandom);
            br_target = $urandom;
            jr_target = $urandom;
            epc       = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                br_target[1:0] = 2'b00; jr_target[1:0] = 2'b00; epc[1:0] = 2'b00;
            end
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
